// File: rtl/spu_load_sequencer_if.sv
// Host word stream and IMEM/RF preload bus of the SPU boot-time load sequencer.
// The sequencer uses the slave modport; the host or bench drives through master.
interface spu_load_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic [0:31]       in_data;
    logic              in_ready;
    logic              load_en;
    logic [0:ADDR_W-1] instr_load_addr;
    logic [0:31]       instruction_in;
    logic              preload_en;
    logic [0:ADDR_W-1] preload_addr;
    logic [0:DATA_W-1] preload_values;
    logic              core_run;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, in_data,
        input  in_ready, load_en, instr_load_addr, instruction_in,
        input  preload_en, preload_addr, preload_values, core_run, busy, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, load_en, instr_load_addr, instruction_in,
        output preload_en, preload_addr, preload_values, core_run, busy, err
    );
endinterface

// File: rtl/spu_load_sequencer.sv
// Boot-time sequencer: turns a 32-bit host word stream into IMEM/RF preload writes, then releases the core.
// Define LOAD_SEQ_CHECKSUM_EN to require a trailing XOR checksum word after every IMEM/RF payload.
module spu_load_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
) (
    input logic                 clk,
    input logic                 rst,
    spu_load_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        IMEM_LD,
        RF_LD,
        CHK,
        RUN,
        ERR
    } state_t;

    localparam logic [1:0] CMD_IMEM  = 2'b00;
    localparam logic [1:0] CMD_RF    = 2'b01;
    localparam logic [1:0] CMD_START = 2'b11;

`ifdef LOAD_SEQ_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CHK;
    localparam logic   BUSY_AFTER    = 1'b1;
`else
    localparam state_t AFTER_PAYLOAD = IDLE;
    localparam logic   BUSY_AFTER    = 1'b0;
`endif

    state_t             state;
    logic [0:ADDR_W-1]  wr_addr;
    logic [0:ADDR_W-1]  remaining;
    logic [1:0]         quad_idx;
    logic [0:DATA_W-33] quad_buf;
`ifdef LOAD_SEQ_CHECKSUM_EN
    logic [0:31]        csum;
`endif

    logic       accept;
    logic       last_entry;
    logic [1:0] hdr_cmd;

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_entry = (remaining == '0);
    assign hdr_cmd    = bus.in_data[0:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            wr_addr              <= '0;
            remaining            <= '0;
            quad_idx             <= '0;
            quad_buf             <= '0;
`ifdef LOAD_SEQ_CHECKSUM_EN
            csum                 <= '0;
`endif
            bus.in_ready         <= 1'b0;
            bus.load_en          <= 1'b0;
            bus.instr_load_addr  <= '0;
            bus.instruction_in   <= '0;
            bus.preload_en       <= 1'b0;
            bus.preload_addr     <= '0;
            bus.preload_values   <= '0;
            bus.core_run         <= 1'b0;
            bus.busy             <= 1'b0;
            bus.err              <= 1'b0;
        end else begin
            bus.load_en    <= 1'b0;
            bus.preload_en <= 1'b0;
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        // remaining holds count-1, so the payload ends when it reads zero
                        wr_addr   <= bus.in_data[2:11];
                        remaining <= bus.in_data[12:21];
                        quad_idx  <= '0;
`ifdef LOAD_SEQ_CHECKSUM_EN
                        csum      <= '0;
`endif
                        case (hdr_cmd)
                            CMD_IMEM: begin
                                state    <= IMEM_LD;
                                bus.busy <= 1'b1;
                            end
                            CMD_RF: begin
                                state    <= RF_LD;
                                bus.busy <= 1'b1;
                            end
                            CMD_START: begin
                                state        <= RUN;
                                bus.core_run <= 1'b1;
                                bus.in_ready <= 1'b0;
                            end
                            default: begin
                                state        <= ERR;
                                bus.err      <= 1'b1;
                                bus.in_ready <= 1'b0;
                            end
                        endcase
                    end
                end
                IMEM_LD: begin
                    if (accept) begin
                        bus.load_en         <= 1'b1;
                        bus.instr_load_addr <= wr_addr;
                        bus.instruction_in  <= bus.in_data;
                        wr_addr             <= wr_addr + 1'b1;
                        remaining           <= remaining - 1'b1;
`ifdef LOAD_SEQ_CHECKSUM_EN
                        csum                <= csum ^ bus.in_data;
`endif
                        if (last_entry) begin
                            state    <= AFTER_PAYLOAD;
                            bus.busy <= BUSY_AFTER;
                        end
                    end
                end
                RF_LD: begin
                    if (accept) begin
`ifdef LOAD_SEQ_CHECKSUM_EN
                        csum <= csum ^ bus.in_data;
`endif
                        // words 0..2 shift into quad_buf; the 4th completes the 128-bit write
                        if (quad_idx == 2'd3) begin
                            bus.preload_en     <= 1'b1;
                            bus.preload_addr   <= wr_addr;
                            bus.preload_values <= {quad_buf, bus.in_data};
                            wr_addr            <= wr_addr + 1'b1;
                            remaining          <= remaining - 1'b1;
                            quad_idx           <= '0;
                            if (last_entry) begin
                                state    <= AFTER_PAYLOAD;
                                bus.busy <= BUSY_AFTER;
                            end
                        end else begin
                            quad_buf <= {quad_buf[32:DATA_W-33], bus.in_data};
                            quad_idx <= quad_idx + 2'd1;
                        end
                    end
                end
`ifdef LOAD_SEQ_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        bus.busy <= 1'b0;
                        if (bus.in_data == csum) begin
                            state <= IDLE;
                        end else begin
                            state        <= ERR;
                            bus.err      <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
`endif
                RUN, ERR: begin
                    bus.in_ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
